// File: rtl/bp_pkg.sv
// bp_pkg: shared types, counter encodings and saturating-counter helpers for the branch predictor.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT   = 2'b00;
    localparam ctr_t CTR_WNT   = 2'b01;
    localparam ctr_t CTR_WT    = 2'b10;
    localparam ctr_t CTR_ST    = 2'b11;
    localparam ctr_t CTR_ALLOC = CTR_WT;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : c + 2'b01;
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// branch_target_predictor_if: fetch lookup and execute update/mispredict signals of the branch predictor.
//   Fetch:   PCF -> PredTakenF, PredTargetF
//   Execute: BranchE, FlushE, TakenE, PCE, TargetE, PredTakenE, PredTargetE -> MispredictE, RedirectPCE
//   master = pipeline side (drives PCs and resolutions), slave = predictor.
interface branch_target_predictor_if #(
    parameter int XLEN = 32
);

    logic [XLEN-1:0] PCF;
    logic            PredTakenF;
    logic [XLEN-1:0] PredTargetF;
    logic            BranchE;
    logic            FlushE;
    logic            TakenE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] TargetE;
    logic            PredTakenE;
    logic [XLEN-1:0] PredTargetE;
    logic            MispredictE;
    logic [XLEN-1:0] RedirectPCE;

    modport master (
        output PCF, BranchE, FlushE, TakenE, PCE, TargetE, PredTakenE, PredTargetE,
        input  PredTakenF, PredTargetF, MispredictE, RedirectPCE
    );

    modport slave (
        input  PCF, BranchE, FlushE, TakenE, PCE, TargetE, PredTakenE, PredTargetE,
        output PredTakenF, PredTargetF, MispredictE, RedirectPCE
    );

endinterface

// File: rtl/bp_table.sv
// bp_table: direct-mapped BTB storage; combinational fetch read, read-modify-write update port, async clear of valid/ctr.
//   clk, reset_n          clock, asynchronous active-low clear of valid and ctr
//   rd_idx_i -> rd_*_o    fetch-side entry read
//   wr_idx_i -> wr_*_o    current contents of the entry addressed for update
//   wr_en_i, wr_tag_i, wr_target_i, wr_ctr_i   entry write (sets valid)
module bp_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32,
    parameter int IW      = $clog2(ENTRIES),
    parameter int TW      = XLEN - IW - 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [IW-1:0]   rd_idx_i,
    output logic            rd_valid_o,
    output logic [TW-1:0]   rd_tag_o,
    output logic [XLEN-1:0] rd_target_o,
    output ctr_t            rd_ctr_o,
    input  logic [IW-1:0]   wr_idx_i,
    output logic            wr_valid_o,
    output logic [TW-1:0]   wr_tag_o,
    output logic [XLEN-1:0] wr_target_o,
    output ctr_t            wr_ctr_o,
    input  logic            wr_en_i,
    input  logic [TW-1:0]   wr_tag_i,
    input  logic [XLEN-1:0] wr_target_i,
    input  ctr_t            wr_ctr_i
);

    logic [ENTRIES-1:0] valid_q;
    ctr_t               ctr_q    [ENTRIES];
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];

    assign wr_valid_o  = valid_q[wr_idx_i];
    assign wr_tag_o    = tag_q[wr_idx_i];
    assign wr_target_o = target_q[wr_idx_i];
    assign wr_ctr_o    = ctr_q[wr_idx_i];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_SNT;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            ctr_q[wr_idx_i]   <= wr_ctr_i;
        end
    end

    // Tag and target are only meaningful behind valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: BTB with 2-bit direction counters; fetch prediction, execute update and mispredict/redirect.
//   clk, reset_n   clock, asynchronous active-low reset (clears all entries)
//   bus (slave)    PCF/PredTakenF/PredTargetF lookup; BranchE..PredTargetE resolution in, MispredictE/RedirectPCE out
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    branch_target_predictor_if.slave    bus
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = XLEN - IW - 2;

    logic [IW-1:0]   f_idx, e_idx;
    logic [TW-1:0]   f_tag, e_tag, rd_tag, wr_tag_old, wr_tag;
    logic [XLEN-1:0] rd_target, wr_target_old, wr_target;
    logic            rd_valid, wr_valid_old, wr_en;
    ctr_t            rd_ctr, wr_ctr_old, wr_ctr;
    logic            hit_f, hit_e, upd;

    assign f_idx = bus.PCF[IW+1:2];
    assign f_tag = bus.PCF[XLEN-1:IW+2];
    assign e_idx = bus.PCE[IW+1:2];
    assign e_tag = bus.PCE[XLEN-1:IW+2];

    bp_table #(
        .ENTRIES (ENTRIES),
        .XLEN    (XLEN)
    ) u_table (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_idx_i    (f_idx),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
        .rd_ctr_o    (rd_ctr),
        .wr_idx_i    (e_idx),
        .wr_valid_o  (wr_valid_old),
        .wr_tag_o    (wr_tag_old),
        .wr_target_o (wr_target_old),
        .wr_ctr_o    (wr_ctr_old),
        .wr_en_i     (wr_en),
        .wr_tag_i    (wr_tag),
        .wr_target_i (wr_target),
        .wr_ctr_i    (wr_ctr)
    );

    assign hit_f           = rd_valid && (rd_tag == f_tag);
    assign bus.PredTakenF  = hit_f && rd_ctr[1];
    assign bus.PredTargetF = bus.PredTakenF ? rd_target : bus.PCF + XLEN'(4);

    // A hit always trains the counter; a miss allocates only when taken.
    always_comb begin
        upd       = bus.BranchE && !bus.FlushE;
        hit_e     = wr_valid_old && (wr_tag_old == e_tag);
        wr_en     = upd && (hit_e || bus.TakenE);
        wr_tag    = e_tag;
        wr_target = bus.TakenE ? bus.TargetE : wr_target_old;
        wr_ctr    = !hit_e ? CTR_ALLOC : bus.TakenE ? sat_inc(wr_ctr_old) : sat_dec(wr_ctr_old);
    end

    assign bus.MispredictE = bus.BranchE && !bus.FlushE &&
                             ((bus.PredTakenE != bus.TakenE) ||
                              (bus.TakenE && (bus.PredTargetE != bus.TargetE)));
    assign bus.RedirectPCE = bus.TakenE ? bus.TargetE : bus.PCE + XLEN'(4);

    logic unused_tag_old;
    assign unused_tag_old = ^wr_tag_old & 1'b0;

endmodule
